// File: rtl/deser_pkg.sv
// Shared types and defaults for the serial-to-parallel deserializer.
package deser_pkg;

  localparam int DESER_DATA_W = 16;

  typedef logic [$clog2(DESER_DATA_W+1)-1:0] cnt_t;

  typedef enum logic {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } deser_state_t;

endpackage

// File: rtl/deser_gap_timer.sv
// Idle-gap timer: counts consecutive idle cycles inside a partial word and
// flags the cycle on which the gap reaches GAP_CYCLES.
module deser_gap_timer #(
  parameter int GAP_CYCLES = 1,
  parameter int CNT_W      = 5
) (
  input  logic clk_i,
  input  logic srst_i,
  input  logic clear,
  input  logic inc,
  output logic expire
);

  logic [CNT_W-1:0] gap_reg;
  logic [CNT_W-1:0] gap_next;

  // Expiry is combinational so the flush lands on the same edge that
  // samples the GAP_CYCLES-th idle cycle.
  always_comb begin
    gap_next = gap_reg;
    expire   = inc && (gap_reg == CNT_W'(GAP_CYCLES - 1));
    if (clear || expire) begin
      gap_next = '0;
    end else if (inc && (gap_reg < CNT_W'(GAP_CYCLES))) begin
      gap_next = gap_reg + CNT_W'(1);
    end
  end

  // Gap counter register, cleared by active-low synchronous reset.
  always_ff @(posedge clk_i) begin
    if (!srst_i) begin
      gap_reg <= '0;
    end else begin
      gap_reg <= gap_next;
    end
  end

endmodule

// File: rtl/deserializer.sv
// Rebuilds left-aligned parallel words from an MSB-first serial stream.
// Optional feature macro: DESER_GAP_FLUSH_EN closes a partial word after
// GAP_CYCLES idle cycles; without it only full DATA_W-bit words are emitted.
module deserializer
  import deser_pkg::*;
#(
  parameter int DATA_W     = DESER_DATA_W,
  parameter int GAP_CYCLES = 1
) (
  input  logic                         clk_i,
  input  logic                         srst_i,
  input  logic                         data_i,
  input  logic                         data_val_i,
  output logic [DATA_W-1:0]            deser_data_o,
  output logic [$clog2(DATA_W+1)-1:0]  deser_data_len_o,
  output logic                         deser_data_val_o
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  deser_state_t      state;
  logic [CNT_W-1:0]  cnt_reg,   cnt_next;
  logic [DATA_W-1:0] shift_reg, shift_next;
  logic [DATA_W-1:0] shift_upd;
  logic [DATA_W-1:0] word_reg,  word_next;
  logic [CNT_W-1:0]  len_reg,   len_next;
  logic              val_reg,   val_next;
  logic              gap_expire;

  assign state = (cnt_reg == '0) ? IDLE : COLLECT;

  // Bit k of a word lands at position DATA_W-1-k; other positions keep
  // their value, so unfilled LSBs stay at the zero left by the last clear.
  genvar gi;
  generate
    for (gi = 0; gi < DATA_W; gi++) begin : g_place
      assign shift_upd[gi] = (cnt_reg == CNT_W'(DATA_W - 1 - gi)) ? data_i : shift_reg[gi];
    end
  endgenerate

`ifdef DESER_GAP_FLUSH_EN
  deser_gap_timer #(
    .GAP_CYCLES (GAP_CYCLES),
    .CNT_W      (CNT_W)
  ) u_gap_timer (
    .clk_i  (clk_i),
    .srst_i (srst_i),
    .clear  (data_val_i || (state == IDLE)),
    .inc    ((state == COLLECT) && !data_val_i),
    .expire (gap_expire)
  );
`else
  assign gap_expire = 1'b0;
`endif

  // Next-state logic: accept a bit, close a full word, or flush on a gap.
  always_comb begin
    cnt_next   = cnt_reg;
    shift_next = shift_reg;
    word_next  = word_reg;
    len_next   = len_reg;
    val_next   = 1'b0;
    if (data_val_i) begin
      if (cnt_reg == CNT_W'(DATA_W - 1)) begin
        word_next  = shift_upd;
        len_next   = CNT_W'(DATA_W);
        val_next   = 1'b1;
        cnt_next   = '0;
        shift_next = '0;
      end else begin
        cnt_next   = cnt_reg + CNT_W'(1);
        shift_next = shift_upd;
      end
    end else if (gap_expire) begin
      word_next  = shift_reg;
      len_next   = cnt_reg;
      val_next   = 1'b1;
      cnt_next   = '0;
      shift_next = '0;
    end
  end

  // State and output registers; reset discards any partial word.
  always_ff @(posedge clk_i) begin
    if (!srst_i) begin
      cnt_reg   <= '0;
      shift_reg <= '0;
      word_reg  <= '0;
      len_reg   <= '0;
      val_reg   <= 1'b0;
    end else begin
      cnt_reg   <= cnt_next;
      shift_reg <= shift_next;
      word_reg  <= word_next;
      len_reg   <= len_next;
      val_reg   <= val_next;
    end
  end

  assign deser_data_o     = word_reg;
  assign deser_data_len_o = len_reg;
  assign deser_data_val_o = val_reg;

endmodule

// File: tb/tb_deserializer.sv
// Directed bench for deserializer: one instance with GAP_CYCLES=1, one with 3.
module tb_deserializer;

  localparam int DW = 16;
  localparam int LW = $clog2(DW + 1);

  logic          clk_i      = 1'b0;
  logic          srst_i     = 1'b0;
  logic          data_i     = 1'b0;
  logic          data_val_i = 1'b0;
  logic [DW-1:0] d1, d3;
  logic [LW-1:0] l1, l3;
  logic          v1, v3;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  deserializer #(.DATA_W(DW), .GAP_CYCLES(1)) u_dut (
    .clk_i            (clk_i),
    .srst_i           (srst_i),
    .data_i           (data_i),
    .data_val_i       (data_val_i),
    .deser_data_o     (d1),
    .deser_data_len_o (l1),
    .deser_data_val_o (v1)
  );

  deserializer #(.DATA_W(DW), .GAP_CYCLES(3)) u_dut3 (
    .clk_i            (clk_i),
    .srst_i           (srst_i),
    .data_i           (data_i),
    .data_val_i       (data_val_i),
    .deser_data_o     (d3),
    .deser_data_len_o (l3),
    .deser_data_val_o (v3)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) cyc <= cyc + 1;

  // Strobe log for the GAP_CYCLES=1 instance, sampled on the falling edge.
  int            n1 = 0;
  logic [DW-1:0] sd [16];
  logic [LW-1:0] sl [16];
  int            sc [16];
  always @(negedge clk_i) begin
    if (v1) begin
      sd[n1 % 16] = d1;
      sl[n1 % 16] = l1;
      sc[n1 % 16] = cyc;
      n1 = n1 + 1;
    end
  end

  // Strobe count for the GAP_CYCLES=3 instance.
  int n3 = 0;
  always @(negedge clk_i) begin
    if (v3) n3 = n3 + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s = 0x%0h", tag, got);
    end
  endtask

  task automatic step(input logic v, input logic d);
    data_val_i = v;
    data_i     = d;
    @(posedge clk_i);
    #1;
  endtask

  task automatic send_word(input logic [15:0] w, input int nbits);
    for (int i = 0; i < nbits; i++) step(1'b1, w[15-i]);
  endtask

  task automatic do_reset();
    srst_i = 1'b0;
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    srst_i = 1'b1;
  endtask

  int base;
  int base3;

  initial begin
    // Reset state
    do_reset();
    check("rst_val", 32'(v1), 32'h0);
    check("rst_data", 32'(d1), 32'h0);
    check("rst_len", 32'(l1), 32'h0);

    // Full word, idle-cycle data must be ignored afterwards
    send_word(16'hA5C3, 16);
    check("full_val", 32'(v1), 32'h1);
    check("full_data", 32'(d1), 32'hA5C3);
    check("full_len", 32'(l1), 32'd16);
    step(1'b0, 1'b1);
    check("full_val_drop", 32'(v1), 32'h0);
    check("full_data_hold", 32'(d1), 32'hA5C3);

    // Short burst 1,0,1 then idle (data_i=1 while idle)
    do_reset();
    base = n1;
    step(1'b1, 1'b1);
    step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    step(1'b0, 1'b1);
`ifdef DESER_GAP_FLUSH_EN
    check("gap_val", 32'(v1), 32'h1);
    check("gap_data", 32'(d1), 32'hA000);
    check("gap_len", 32'(l1), 32'd3);
    step(1'b0, 1'b1);
    check("gap_val_drop", 32'(v1), 32'h0);
    check("gap_strobes", 32'(n1 - base), 32'd1);
`else
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    check("hold_no_strobe", 32'(n1 - base), 32'd0);
    for (int i = 0; i < 13; i++) step(1'b1, 1'b1);
    check("hold_val", 32'(v1), 32'h1);
    check("hold_data", 32'(d1), 32'hBFFF);
    check("hold_len", 32'(l1), 32'd16);
`endif

    // Back-to-back words with no idle cycle
    do_reset();
    base = n1;
    send_word(16'hFFFF, 16);
    send_word(16'h0001, 16);
    step(1'b0, 1'b0);
    check("b2b_strobes", 32'(n1 - base), 32'd2);
    check("b2b_data0", 32'(sd[base % 16]), 32'hFFFF);
    check("b2b_data1", 32'(sd[(base + 1) % 16]), 32'h0001);
    check("b2b_len1", 32'(sl[(base + 1) % 16]), 32'd16);
    check("b2b_spacing", 32'(sc[(base + 1) % 16] - sc[base % 16]), 32'd16);

    // Mid-word reset with a valid bit present on the reset cycle
    base = n1;
    send_word(16'hFE00, 7);
    srst_i = 1'b0;
    step(1'b1, 1'b1);
    srst_i = 1'b1;
    check("mrst_val", 32'(v1), 32'h0);
    check("mrst_len", 32'(l1), 32'h0);
    send_word(16'h1234, 16);
    check("mrst_word_val", 32'(v1), 32'h1);
    check("mrst_word_data", 32'(d1), 32'h1234);
    check("mrst_word_len", 32'(l1), 32'd16);
    step(1'b0, 1'b0);
    check("mrst_strobes", 32'(n1 - base), 32'd1);

    // Gap timing on the GAP_CYCLES=3 instance
    do_reset();
    base3 = n3;
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    step(1'b1, 1'b0);
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    check("gap3_early", 32'(n3 - base3), 32'd0);
    step(1'b0, 1'b1);
`ifdef DESER_GAP_FLUSH_EN
    check("gap3_val", 32'(v3), 32'h1);
    check("gap3_data", 32'(d3), 32'hC000);
    check("gap3_len", 32'(l3), 32'd3);
    step(1'b0, 1'b0);
    check("gap3_strobes", 32'(n3 - base3), 32'd1);
`else
    check("gap3_val", 32'(v3), 32'h0);
    step(1'b0, 1'b0);
    check("gap3_strobes", 32'(n3 - base3), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
